// File: rtl/tcm_boot_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tcm_boot_pkg: shared types and opcode constants for TCM boot      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package tcm_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RST_CORE = 3'd2,
    ST_RUN      = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam logic [6:0] OP_R_M      = 7'd51;
  localparam logic [6:0] OP_I_ARITH  = 7'd19;
  localparam logic [6:0] OP_LOAD     = 7'd3;
  localparam logic [6:0] OP_STORE    = 7'd35;
  localparam logic [6:0] OP_BRANCH   = 7'd99;
  localparam logic [6:0] OP_JALR     = 7'd103;
  localparam logic [6:0] OP_JAL      = 7'd111;
  localparam logic [6:0] OP_AUIPC    = 7'd23;
  localparam logic [6:0] OP_LUI      = 7'd55;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_ETC    = 3'd4,
    CLS_NONE   = 3'd5
  } cls_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tcm_boot_classify.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tcm_boot_classify: combinational opcode to instruction class      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tcm_boot_classify
  import tcm_boot_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_e       cls
);

  always_comb begin
    cls = CLS_NONE;
    case (opcode)
      OP_R_M, OP_I_ARITH:                 cls = CLS_ALU;
      OP_LOAD:                            cls = CLS_LOAD;
      OP_STORE:                           cls = CLS_STORE;
      OP_BRANCH:                          cls = CLS_BRANCH;
      OP_JALR, OP_JAL, OP_AUIPC, OP_LUI:  cls = CLS_ETC;
      default:                            cls = CLS_NONE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tcm_boot_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tcm_boot_ctrl: loads a TCM image, runs the core, measures run     |
// | Optional macro TCM_BOOT_PROFILE_EN builds the opcode profiler.    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tcm_boot_ctrl
  import tcm_boot_pkg::*;
#(
  parameter int          DEPTH           = 200,
  parameter logic [31:0] ADDR_BASE       = 32'h0,
  parameter logic [31:0] DONE_INST       = 32'h0000_8067,
  parameter int          CORE_RST_CYCLES = 1,
  parameter int          DRAIN_CYCLES    = 4,
  parameter logic [31:0] MAX_CYCLES      = 32'd100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        src_valid_i,
  input  logic [31:0] src_data_i,
  output logic        src_ready_o,
  output logic [3:0]  tcm_we_o,
  output logic [31:0] tcm_addr_o,
  output logic [31:0] tcm_data_o,
  output logic        rst_cpu_o,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_inst_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [31:0] cycle_cnt_o,
  output logic [15:0] cnt_alu_o,
  output logic [15:0] cnt_load_o,
  output logic [15:0] cnt_store_o,
  output logic [15:0] cnt_branch_o,
  output logic [15:0] cnt_etc_o
);

  state_e      r_state, w_next;
  logic [31:0] r_idx, r_wait_cnt, r_cycle_cnt, r_tcm_addr, r_tcm_data;
  logic [3:0]  r_tcm_we;
  logic        r_timeout;
  logic        w_accept, w_last, w_hit, w_limit, w_rst_end, w_drain_end;

  assign w_accept    = (r_state == ST_LOAD) && src_valid_i;
  assign w_last      = w_accept && (r_idx == 32'(DEPTH - 1));
  assign w_hit       = fetch_valid_i && (fetch_inst_i == DONE_INST);
  assign w_limit     = (r_cycle_cnt == MAX_CYCLES - 32'd1);
  // r_wait_cnt restarts at 0 on every state change, so it times the current state.
  assign w_rst_end   = (r_wait_cnt + 32'd1) >= 32'(CORE_RST_CYCLES);
  assign w_drain_end = (r_wait_cnt + 32'd1) >= 32'(DRAIN_CYCLES);

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    src_ready_o = 1'b0;
    rst_cpu_o   = 1'b1;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        src_ready_o = 1'b1;
        if (w_last) w_next = ST_RST_CORE;
      end
      ST_RST_CORE: begin
        if (w_rst_end) w_next = ST_RUN;
      end
      ST_RUN: begin
        rst_cpu_o = 1'b0;
        if (w_hit)        w_next = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
        else if (w_limit) w_next = ST_DONE;
      end
      ST_DRAIN: begin
        rst_cpu_o = 1'b0;
        if (w_drain_end) w_next = ST_DONE;
      end
      ST_DONE: begin
        busy_o = 1'b0;
        done_o = 1'b1;
        if (start_i) w_next = ST_LOAD;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_idx       <= '0;
      r_wait_cnt  <= '0;
      r_cycle_cnt <= '0;
      r_tcm_we    <= '0;
      r_tcm_addr  <= '0;
      r_tcm_data  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_tcm_we   <= 4'h0;
      r_wait_cnt <= (w_next != r_state) ? 32'd0 : r_wait_cnt + 32'd1;
      if (w_accept) begin
        r_tcm_we   <= 4'hF;
        r_tcm_addr <= ADDR_BASE + {r_idx[29:0], 2'b00};
        r_tcm_data <= src_data_i;
        r_idx      <= r_idx + 32'd1;
      end
      case (r_state)
        ST_IDLE: begin
          r_idx       <= '0;
          r_cycle_cnt <= '0;
          r_timeout   <= 1'b0;
        end
        ST_RUN: begin
          if (w_hit)        r_cycle_cnt <= r_cycle_cnt + 32'(DRAIN_CYCLES);
          else if (w_limit) r_timeout   <= 1'b1;
          else              r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
        ST_DONE: begin
          if (start_i) begin
            r_idx       <= '0;
            r_cycle_cnt <= '0;
            r_timeout   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign tcm_we_o    = r_tcm_we;
  assign tcm_addr_o  = r_tcm_addr;
  assign tcm_data_o  = r_tcm_data;
  assign timeout_o   = r_timeout;
  assign cycle_cnt_o = r_cycle_cnt;

`ifdef TCM_BOOT_PROFILE_EN
  cls_e        w_cls;
  logic        w_clear;
  logic [15:0] r_cnt_alu, r_cnt_load, r_cnt_store, r_cnt_branch, r_cnt_etc;

  assign w_clear = (r_state == ST_IDLE) || ((r_state == ST_DONE) && start_i);

  tcm_boot_classify u_classify (
    .opcode (src_data_i[6:0]),
    .cls    (w_cls)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i || w_clear) begin
      r_cnt_alu    <= '0;
      r_cnt_load   <= '0;
      r_cnt_store  <= '0;
      r_cnt_branch <= '0;
      r_cnt_etc    <= '0;
    end else if (w_accept) begin
      case (w_cls)
        CLS_ALU:    r_cnt_alu    <= sat_inc16(r_cnt_alu);
        CLS_LOAD:   r_cnt_load   <= sat_inc16(r_cnt_load);
        CLS_STORE:  r_cnt_store  <= sat_inc16(r_cnt_store);
        CLS_BRANCH: r_cnt_branch <= sat_inc16(r_cnt_branch);
        CLS_ETC:    r_cnt_etc    <= sat_inc16(r_cnt_etc);
        default: ;
      endcase
    end
  end

  assign cnt_alu_o    = r_cnt_alu;
  assign cnt_load_o   = r_cnt_load;
  assign cnt_store_o  = r_cnt_store;
  assign cnt_branch_o = r_cnt_branch;
  assign cnt_etc_o    = r_cnt_etc;
`else
  assign cnt_alu_o    = 16'h0;
  assign cnt_load_o   = 16'h0;
  assign cnt_store_o  = 16'h0;
  assign cnt_branch_o = 16'h0;
  assign cnt_etc_o    = 16'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tcm_boot_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_tcm_boot_ctrl: directed self-checking bench for tcm_boot_ctrl  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_tcm_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, src_valid, fetch_valid;
  logic [31:0] src_data, fetch_inst;
  logic        src_ready, rst_cpu, busy, done, timeout;
  logic [3:0]  tcm_we;
  logic [31:0] tcm_addr, tcm_data, cycle_cnt;
  logic [15:0] c_alu, c_load, c_store, c_branch, c_etc;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [3:0]  wr_we[$];

  logic [31:0] w_img[4] = '{32'h0000_0013, 32'h0000_2083, 32'h0011_2023, 32'h0000_8067};
  logic [31:0] g_img[4] = '{32'h0000_0063, 32'h0000_006F, 32'h0000_0033, 32'h0000_007F};

  always #5 clk = ~clk;

  tcm_boot_ctrl #(
    .DEPTH(4), .ADDR_BASE(32'h0), .DONE_INST(32'h0000_8067),
    .CORE_RST_CYCLES(1), .DRAIN_CYCLES(4), .MAX_CYCLES(32'd20)
  ) u_dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
    .src_valid_i(src_valid), .src_data_i(src_data), .src_ready_o(src_ready),
    .tcm_we_o(tcm_we), .tcm_addr_o(tcm_addr), .tcm_data_o(tcm_data),
    .rst_cpu_o(rst_cpu), .fetch_valid_i(fetch_valid), .fetch_inst_i(fetch_inst),
    .busy_o(busy), .done_o(done), .timeout_o(timeout), .cycle_cnt_o(cycle_cnt),
    .cnt_alu_o(c_alu), .cnt_load_o(c_load), .cnt_store_o(c_store),
    .cnt_branch_o(c_branch), .cnt_etc_o(c_etc)
  );

`ifdef TCM_BOOT_PROFILE_EN
  logic        s_start;
  logic        s_ready, s_rst_cpu, s_busy, s_done, s_timeout;
  logic [3:0]  s_we;
  logic [31:0] s_addr, s_data, s_cycle;
  logic [15:0] s_alu, s_load, s_store, s_branch, s_etc;

  tcm_boot_ctrl #(
    .DEPTH(70000), .MAX_CYCLES(32'd3)
  ) u_sat (
    .clk_i(clk), .rst_i(rst_n), .start_i(s_start),
    .src_valid_i(1'b1), .src_data_i(32'h0000_0013), .src_ready_o(s_ready),
    .tcm_we_o(s_we), .tcm_addr_o(s_addr), .tcm_data_o(s_data),
    .rst_cpu_o(s_rst_cpu), .fetch_valid_i(1'b0), .fetch_inst_i(32'h0),
    .busy_o(s_busy), .done_o(s_done), .timeout_o(s_timeout), .cycle_cnt_o(s_cycle),
    .cnt_alu_o(s_alu), .cnt_load_o(s_load), .cnt_store_o(s_store),
    .cnt_branch_o(s_branch), .cnt_etc_o(s_etc)
  );
`endif

  always @(negedge clk) begin
    if (tcm_we !== 4'h0) begin
      wr_we.push_back(tcm_we);
      wr_addr.push_back(tcm_addr);
      wr_data.push_back(tcm_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_prof(input int a, input int l, input int s, input int b, input int e);
`ifdef TCM_BOOT_PROFILE_EN
    check("cnt_alu",    32'(c_alu),    32'(a));
    check("cnt_load",   32'(c_load),   32'(l));
    check("cnt_store",  32'(c_store),  32'(s));
    check("cnt_branch", 32'(c_branch), 32'(b));
    check("cnt_etc",    32'(c_etc),    32'(e));
`else
    if (a + l + s + b + e >= 0) begin
      check("cnt_alu_off",    32'(c_alu),    32'h0);
      check("cnt_load_off",   32'(c_load),   32'h0);
      check("cnt_store_off",  32'(c_store),  32'h0);
      check("cnt_branch_off", 32'(c_branch), 32'h0);
      check("cnt_etc_off",    32'(c_etc),    32'h0);
    end
`endif
  endtask

  task automatic check_writes(input string tag, input logic [31:0] img[4]);
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      check({tag, "_we"},   32'(wr_we[i]), 32'hF);
      check({tag, "_addr"}, wr_addr[i],    32'(4 * i));
      check({tag, "_data"}, wr_data[i],    img[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; src_valid = 1'b0; src_data = '0;
    fetch_valid = 1'b0; fetch_inst = '0;
`ifdef TCM_BOOT_PROFILE_EN
    s_start = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_rst_cpu", 32'(rst_cpu),   32'd1);
    check("rst_we",      32'(tcm_we),    32'd0);
    check("rst_addr",    tcm_addr,       32'd0);
    check("rst_busy",    32'(busy),      32'd0);
    check("rst_done",    32'(done),      32'd0);
    check("rst_timeout", 32'(timeout),   32'd0);
    check("rst_ready",   32'(src_ready), 32'd0);
    check("rst_cycle",   cycle_cnt,      32'd0);
    check_prof(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Boot 1: back-to-back words, then DONE_INST at count 10
    start = 1'b1;
`ifdef TCM_BOOT_PROFILE_EN
    s_start = 1'b1;
`endif
    @(negedge clk);
    start = 1'b0;
`ifdef TCM_BOOT_PROFILE_EN
    s_start = 1'b0;
`endif
    check("load_ready", 32'(src_ready), 32'd1);
    check("load_busy",  32'(busy),      32'd1);
    for (int i = 0; i < 4; i++) begin
      src_valid = 1'b1; src_data = w_img[i];
      @(negedge clk);
    end
    src_valid = 1'b0;
    check("last_ready_drop", 32'(src_ready), 32'd0);
    check("last_wr_we",      32'(tcm_we),    32'hF);
    check("last_wr_addr",    tcm_addr,       32'hC);
    check("rstcore_cpu",     32'(rst_cpu),   32'd1);
    @(negedge clk);
    check("run_cpu",   32'(rst_cpu), 32'd0);
    check("run_we",    32'(tcm_we),  32'd0);
    check("run_cnt0",  cycle_cnt,    32'd0);
    check_writes("b1", w_img);
    check_prof(1, 1, 1, 0, 1);
    for (int k = 0; k < 10; k++) begin
      fetch_valid = (k != 5);
      fetch_inst  = (k == 5) ? 32'h0000_8067 : 32'h0000_0013;
      @(negedge clk);
    end
    check("run_cnt10", cycle_cnt, 32'd10);
    fetch_valid = 1'b1; fetch_inst = 32'h0000_8067;
    @(negedge clk);
    fetch_valid = 1'b0;
    check("drain_cnt",  cycle_cnt,    32'd14);
    check("drain_done", 32'(done),    32'd0);
    check("drain_cpu",  32'(rst_cpu), 32'd0);
    repeat (3) @(negedge clk);
    check("drain3_done", 32'(done), 32'd0);
    @(negedge clk);
    check("done_done",    32'(done),    32'd1);
    check("done_cpu",     32'(rst_cpu), 32'd1);
    check("done_busy",    32'(busy),    32'd0);
    check("done_timeout", 32'(timeout), 32'd0);
    check("done_cnt",     cycle_cnt,    32'd14);
    @(negedge clk);
    check("done_hold", cycle_cnt, 32'd14);

    // Boot 2: valid gaps, then run into the 20-cycle limit
    wr_we.delete(); wr_addr.delete(); wr_data.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_done", 32'(done), 32'd0);
    check("restart_cnt",  cycle_cnt, 32'd0);
    check_prof(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      src_valid = 1'b1; src_data = g_img[i];
      @(negedge clk);
      src_valid = 1'b0; src_data = 32'hDEAD_BEEF;
      @(negedge clk);
    end
    check("gap_run_cpu",  32'(rst_cpu), 32'd0);
    check("gap_run_cnt0", cycle_cnt,    32'd0);
    check_writes("b2", g_img);
    check_prof(1, 0, 0, 1, 1);
    repeat (19) @(negedge clk);
    check("to_cnt19_pre", cycle_cnt, 32'd19);
    check("to_done_pre",  32'(done), 32'd0);
    @(negedge clk);
    check("to_done",    32'(done),    32'd1);
    check("to_timeout", 32'(timeout), 32'd1);
    check("to_cnt",     cycle_cnt,    32'd19);
    check("to_cpu",     32'(rst_cpu), 32'd1);

    // Boot 3: reset after two writes, then reload from ADDR_BASE
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b3_timeout_clr", 32'(timeout), 32'd0);
    src_valid = 1'b1; src_data = w_img[0];
    @(negedge clk);
    src_data = w_img[1];
    @(negedge clk);
    check("b3_wr1_addr", tcm_addr, 32'h4);
    rst_n = 1'b0; src_data = w_img[2];
    @(negedge clk);
    check("abort_we",    32'(tcm_we),    32'd0);
    check("abort_cpu",   32'(rst_cpu),   32'd1);
    check("abort_busy",  32'(busy),      32'd0);
    check("abort_ready", 32'(src_ready), 32'd0);
    rst_n = 1'b1; src_valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src_valid = 1'b1; src_data = w_img[i];
      @(negedge clk);
      if (i == 0) begin
        check("reload_we",   32'(tcm_we), 32'hF);
        check("reload_addr", tcm_addr,    32'h0);
        check("reload_data", tcm_data,    w_img[0]);
      end
    end
    src_valid = 1'b0;
    check_prof(1, 1, 1, 0, 1);

`ifdef TCM_BOOT_PROFILE_EN
    for (int t = 0; t < 80000 && s_done !== 1'b1; t++) @(negedge clk);
    check("sat_done", 32'(s_done),   32'd1);
    check("sat_alu",  32'(s_alu),    32'hFFFF);
    check("sat_load", 32'(s_load),   32'd0);
    check("sat_etc",  32'(s_etc),    32'd0);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    check("sat_clr_alu", 32'(s_alu),  32'd0);
    check("sat_clr_done", 32'(s_done), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
